// File: rtl/obi_spi_regs.sv
// obi_spi_regs: OBI slave exposing CTRL/STATUS registers and TX/RX data FIFOs
// in front of an SPI shift engine (valid/ready streams on the engine side).
// Optional feature macro: OBI_SPI_REGS_ERR_EN adds obi_err_o, raised with the
// response for out-of-window, illegal STATUS write, RXDATA-empty read and
// read-only/write-only violations.
module obi_spi_regs #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    WORD_WIDTH = 8,
    parameter int                    TX_DEPTH   = 4,
    parameter int                    RX_DEPTH   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      obi_req_i,
    output logic                      obi_gnt_o,
    input  logic [ADDR_WIDTH-1:0]     obi_addr_i,
    input  logic                      obi_we_i,
    input  logic [DATA_WIDTH/8-1:0]   obi_be_i,
    input  logic [DATA_WIDTH-1:0]     obi_wdata_i,
    output logic                      obi_rvalid_o,
    output logic [DATA_WIDTH-1:0]     obi_rdata_o,
`ifdef OBI_SPI_REGS_ERR_EN
    output logic                      obi_err_o,
`endif
    output logic                      spi_tx_valid_o,
    output logic [WORD_WIDTH-1:0]     spi_tx_data_o,
    input  logic                      spi_tx_ready_i,
    input  logic                      spi_rx_valid_i,
    input  logic [WORD_WIDTH-1:0]     spi_rx_data_i,
    output logic                      spi_rx_ready_o,
    output logic                      spi_en_o,
    output logic [7:0]                spi_clkdiv_o
);

    localparam int TXP = $clog2(TX_DEPTH) + 1;
    localparam int RXP = $clog2(RX_DEPTH) + 1;
    localparam int BEW = DATA_WIDTH / 8;
`ifdef OBI_SPI_REGS_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // Decode
    logic       in_win, hit_ctrl, hit_status, hit_tx, hit_rx;
    logic       accept, wr, rd;
    assign in_win     = (obi_addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]);
    assign hit_ctrl   = in_win && (obi_addr_i[3:2] == 2'd0);
    assign hit_status = in_win && (obi_addr_i[3:2] == 2'd1);
    assign hit_tx     = in_win && (obi_addr_i[3:2] == 2'd2);
    assign hit_rx     = in_win && (obi_addr_i[3:2] == 2'd3);

    // Byte-enable expanded to a bit mask for STATUS write legality
    logic [DATA_WIDTH-1:0] be_mask, wdata_masked;
    genvar gi;
    generate
        for (gi = 0; gi < BEW; gi++) begin : g_be_mask
            assign be_mask[8*gi +: 8] = {8{obi_be_i[gi]}};
        end
    endgenerate
    assign wdata_masked = obi_wdata_i & be_mask;

    // FIFO state
    logic [TXP-1:0]        tx_wptr_reg, tx_rptr_reg, tx_level;
    logic [RXP-1:0]        rx_wptr_reg, rx_rptr_reg, rx_level;
    logic [WORD_WIDTH-1:0] tx_mem [TX_DEPTH];
    logic [WORD_WIDTH-1:0] rx_mem [RX_DEPTH];
    logic                  tx_empty, tx_full, rx_empty, rx_full;

    assign tx_level = tx_wptr_reg - tx_rptr_reg;
    assign rx_level = rx_wptr_reg - rx_rptr_reg;
    assign tx_empty = (tx_wptr_reg == tx_rptr_reg);
    assign rx_empty = (rx_wptr_reg == rx_rptr_reg);
    assign tx_full  = (tx_wptr_reg[TXP-1] != tx_rptr_reg[TXP-1]) &&
                      (tx_wptr_reg[TXP-2:0] == tx_rptr_reg[TXP-2:0]);
    assign rx_full  = (rx_wptr_reg[RXP-1] != rx_rptr_reg[RXP-1]) &&
                      (rx_wptr_reg[RXP-2:0] == rx_rptr_reg[RXP-2:0]);

    // Grant follows request except a TXDATA write into a full TX FIFO
    assign obi_gnt_o = obi_req_i && !(hit_tx && obi_we_i && tx_full);
    assign accept    = obi_req_i && obi_gnt_o;
    assign wr        = accept && obi_we_i;
    assign rd        = accept && !obi_we_i;

    // Control and status side effects
    logic ctrl_wr, tx_flush, rx_flush, status_bad, uf_set, uf_clear;
    logic tx_push, tx_pop, rx_push, rx_pop;
    logic ctrl_en_reg, underflow_reg;
    logic [7:0] clkdiv_reg;

    assign ctrl_wr    = wr && hit_ctrl;
    assign tx_flush   = ctrl_wr && obi_be_i[0] && obi_wdata_i[1];
    assign rx_flush   = ctrl_wr && obi_be_i[0] && obi_wdata_i[2];
    assign status_bad = |{wdata_masked[DATA_WIDTH-1:5], wdata_masked[3:0]};
    assign uf_clear   = wr && hit_status && !(ERR_EN && status_bad);
    assign uf_set     = rd && hit_rx && rx_empty;

    assign tx_push = wr && hit_tx && (|obi_be_i);
    assign tx_pop  = !tx_empty && spi_tx_ready_i && !tx_flush;
    assign rx_push = spi_rx_valid_i && !rx_full && !rx_flush;
    assign rx_pop  = rd && hit_rx && !rx_empty;

    assign spi_tx_valid_o = !tx_empty;
    assign spi_tx_data_o  = tx_empty ? '0 : tx_mem[tx_rptr_reg[TXP-2:0]];
    assign spi_rx_ready_o = !rx_full;
    assign spi_en_o       = ctrl_en_reg;
    assign spi_clkdiv_o   = clkdiv_reg;

    // CTRL register with per-byte enables; flush bits are not stored
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            ctrl_en_reg <= 1'b0;
            clkdiv_reg  <= 8'h00;
        end else if (ctrl_wr) begin
            if (obi_be_i[0]) ctrl_en_reg <= obi_wdata_i[0];
            if (obi_be_i[1]) clkdiv_reg  <= obi_wdata_i[15:8];
        end
    end

    // Sticky RX underflow flag
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i)       underflow_reg <= 1'b0;
        else if (uf_set)   underflow_reg <= 1'b1;
        else if (uf_clear) underflow_reg <= 1'b0;
    end

    // TX pointers; flush wins over the engine-side pop
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            tx_wptr_reg <= '0;
            tx_rptr_reg <= '0;
        end else if (tx_flush) begin
            tx_wptr_reg <= '0;
            tx_rptr_reg <= '0;
        end else begin
            if (tx_push) tx_wptr_reg <= tx_wptr_reg + TXP'(1);
            if (tx_pop)  tx_rptr_reg <= tx_rptr_reg + TXP'(1);
        end
    end

    // RX pointers; flush wins over the engine-side push
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rx_wptr_reg <= '0;
            rx_rptr_reg <= '0;
        end else if (rx_flush) begin
            rx_wptr_reg <= '0;
            rx_rptr_reg <= '0;
        end else begin
            if (rx_push) rx_wptr_reg <= rx_wptr_reg + RXP'(1);
            if (rx_pop)  rx_rptr_reg <= rx_rptr_reg + RXP'(1);
        end
    end

    // FIFO storage writes (no reset needed; pointers gate visibility)
    always_ff @(posedge clk_i) begin
        if (tx_push) tx_mem[tx_wptr_reg[TXP-2:0]] <= obi_wdata_i[WORD_WIDTH-1:0];
        if (rx_push) rx_mem[rx_wptr_reg[RXP-2:0]] <= spi_rx_data_i;
    end

    // Read data mux and error classification for the current request
    logic [DATA_WIDTH-1:0] rdata_next, rdata_reg;
    logic                  err_next, rvalid_reg;
    always_comb begin
        rdata_next = '0;
        err_next   = !in_win;
        if (rd) begin
            if (hit_ctrl) begin
                rdata_next[0]    = ctrl_en_reg;
                rdata_next[15:8] = clkdiv_reg;
            end else if (hit_status) begin
                rdata_next[0]     = tx_full;
                rdata_next[1]     = tx_empty;
                rdata_next[2]     = rx_full;
                rdata_next[3]     = rx_empty;
                rdata_next[4]     = underflow_reg;
                rdata_next[15:8]  = 8'(tx_level);
                rdata_next[23:16] = 8'(rx_level);
            end else if (hit_rx && !rx_empty) begin
                rdata_next[WORD_WIDTH-1:0] = rx_mem[rx_rptr_reg[RXP-2:0]];
            end
        end
        if (hit_status && obi_we_i && status_bad) err_next = 1'b1;
        if (hit_rx && (obi_we_i || rx_empty))     err_next = 1'b1;
        if (hit_tx && !obi_we_i)                  err_next = 1'b1;
    end

    // Response: one registered beat per granted cycle
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rvalid_reg <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            rvalid_reg <= accept;
            rdata_reg  <= rdata_next;
        end
    end

    assign obi_rvalid_o = rvalid_reg;
    assign obi_rdata_o  = rdata_reg;

`ifdef OBI_SPI_REGS_ERR_EN
    logic err_reg;
    // Error flag travels with the response beat
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) err_reg <= 1'b0;
        else         err_reg <= accept && err_next;
    end
    assign obi_err_o = err_reg;
`endif

    logic unused_ok;
    assign unused_ok = ^{obi_addr_i[1:0], obi_wdata_i, err_next};

endmodule

// File: doc/obi_spi_regs.md
# obi_spi_regs

OBI slave giving a host core a register interface to an SPI engine: control register, status register, and parametrised TX/RX data FIFOs. Sits between the system OBI interconnect and the SPI shift engine, which it drives through valid/ready streams. Successor to the single-state OBI slave: adds real grant/response sequencing, byte enables, address decode, FIFO buffering and back-pressure.

## Interface
- ADDR_WIDTH, 32, OBI address width
- DATA_WIDTH, 32, OBI data width (must be 32)
- WORD_WIDTH, 8, SPI word width (1..DATA_WIDTH)
- TX_DEPTH, 4, TX FIFO entries (power of 2, ≥2)
- RX_DEPTH, 4, RX FIFO entries (power of 2, ≥2)
- BASE_ADDR, 32'h0000, base of the 16-byte register window
- clk_i  in  1  sole clock, rising edge
- rstn_i  in  1  asynchronous active-low reset
- obi_req_i  in  1  request
- obi_gnt_o  out  1  grant
- obi_addr_i  in  ADDR_WIDTH  byte address
- obi_we_i  in  1  write enable
- obi_be_i  in  DATA_WIDTH/8  byte enables
- obi_wdata_i  in  DATA_WIDTH  write data
- obi_rvalid_o  out  1  response valid
- obi_rdata_o  out  DATA_WIDTH  read data
- spi_tx_valid_o / spi_tx_data_o / spi_tx_ready_i  out/out/in  1/WORD_WIDTH/1  TX stream to engine
- spi_rx_valid_i / spi_rx_data_i / spi_rx_ready_o  in/in/out  1/WORD_WIDTH/1  RX stream from engine
- spi_en_o  out  1  CTRL.enable
- spi_clkdiv_o  out  8  CTRL.clkdiv

## Operation
- Decode on addr[3:2] when addr[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4]; addr[1:0] ignored.
- 0x0 CTRL RW: bit0 enable, bit1 tx_flush (W1, self-clearing, reads 0), bit2 rx_flush (same), bits[15:8] clkdiv; rest reads 0. Byte-enable honoured per byte.
- 0x4 STATUS RO: [0] tx_full, [1] tx_empty, [2] rx_full, [3] rx_empty, [4] rx_underflow (sticky, cleared by any write to STATUS), [15:8] tx_level, [23:16] rx_level (zero-extended).
- 0x8 TXDATA WO: write pushes wdata[WORD_WIDTH-1:0] if obi_be_i != 0; reads return 0.
- 0xC RXDATA RO: read pops head, returns it zero-extended; on empty returns 0, no pop, sets rx_underflow. Writes ignored.
- Out-of-window: writes ignored, reads return 0, still granted and responded.
- FIFOs: circular buffers, pointers one bit wider than log2(depth); level = wptr − rptr. spi_tx_valid_o = !tx_empty, spi_tx_data_o = head. spi_rx_ready_o = !rx_full.
- Flush empties the FIFO in the write's cycle; a same-cycle SPI-side push/pop on that FIFO is dropped.
- Reset: all outputs 0, CTRL 0, FIFOs empty, underflow 0. Reset mid-transaction drops any pending response.

## Timing
- obi_gnt_o combinational: = obi_req_i, except 0 for a TXDATA write while tx_full (held until space).
- Full evaluated on registered state: SPI pop in the same cycle does not enable a grant (no bypass).
- Response: obi_rvalid_o high exactly one cycle after each granted cycle, one per grant; obi_rdata_o registered, valid only with rvalid, 0 otherwise and for writes.
- Back-to-back grants every cycle supported; response n+1 follows response n.
- Push/pop visible in STATUS and stream ports the cycle after the grant. Simultaneous OBI push and SPI pop on TX (or SPI push and OBI pop on RX) both complete; level unchanged.
- CTRL update visible on spi_en_o/spi_clkdiv_o the cycle after grant.

## Configuration
- OBI_SPI_REGS_ERR_EN defined: adds port obi_err_o (out, 1), asserted with rvalid for out-of-window accesses, writes to STATUS bits other than underflow-clear, RXDATA read on empty, and RO/WO violations; error writes have no side effect other than underflow set. Undefined: port absent, behaviour as in Operation.

## Test plan
- Reset then read STATUS -> rvalid 1 cycle after gnt, rdata 0x0000_000A (tx_empty, rx_empty).
- Write CTRL 0x0000_0301 be=4'b0011 -> spi_en_o=1, spi_clkdiv_o=0x03 next cycle; be=4'b0001 write 0x0000_FF00 leaves clkdiv 0x03.
- Push 5 words (TX_DEPTH=4, spi_tx_ready_i=0) -> 4 granted, 5th gnt held low until ready pulses one cycle, then granted; STATUS tx_level=4.
- Drive RX 0xA5, 0x3C -> RXDATA reads return 0x0000_00A5 then 0x0000_003C; third read returns 0, STATUS bit4=1; write STATUS clears it.
- Fill TX, write CTRL bit1 -> tx_level 0, tx_valid low next cycle, CTRL bit1 reads 0.
- Access addr BASE_ADDR+0x20 -> granted, rdata 0; with OBI_SPI_REGS_ERR_EN, obi_err_o=1 with rvalid.
